// File: rtl/reading_history_buf.sv
// reading_history_buf
// History store for the ultrasonic height path. It sits between the inches
// converter and the 7-segment / VGA display blocks.
//   * Debounces converted readings. A reading is committed once STABLE_CNT
//     consecutive non-zero samples stay within TOL of the first sample of
//     the run. Each stable episode commits exactly once.
//   * Keeps the last DEPTH commits in a circular buffer.
//   * Serves a button-browsable entry, an age-indexed read port for the VGA
//     renderer, and min/max statistics that are rebuilt by a sequential scan
//     after every commit.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   clear         (only with HIST_CLEAR_EN defined) one-cycle pulse that
//                 empties the history
//   sample_valid  one-cycle strobe qualifying sample
//   sample        converted reading in inches, 0 = no echo (ignored)
//   browse_step   one-cycle pulse that advances browse_idx
//   rd_age        VGA read age, 0 = newest
//   rd_data       entry at rd_age, one cycle of latency, 0 for ages >= count
//   browse_idx    current browse age
//   browse_data   entry at browse_idx, one cycle of latency
//   count         number of valid entries (saturates at DEPTH)
//   save_pulse    one-cycle pulse in the cycle after a commit
//   min_val/max_val  statistics over the valid entries
//   stats_valid   high when min_val/max_val reflect the current contents
//
// Optional feature macro: HIST_CLEAR_EN (adds the clear input and its logic).
module reading_history_buf #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 10,
    parameter int STABLE_CNT = 4,
    parameter int TOL        = 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef HIST_CLEAR_EN
    input  logic                       clear,
`endif
    input  logic                       sample_valid,
    input  logic [DATA_W-1:0]          sample,
    input  logic                       browse_step,
    input  logic [$clog2(DEPTH)-1:0]   rd_age,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH)-1:0]   browse_idx,
    output logic [DATA_W-1:0]          browse_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       save_pulse,
    output logic [DATA_W-1:0]          min_val,
    output logic [DATA_W-1:0]          max_val,
    output logic                       stats_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(STABLE_CNT + 1);
    localparam logic [DATA_W:0] TOL_EXT = (DATA_W + 1)'(TOL);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   cand_reg, cand_next;
    logic [RW-1:0]       run_reg, run_next;
    logic                commit;

    logic [DATA_W-1:0]   mem_reg [DEPTH];
    logic [AW-1:0]       wr_ptr_reg;

    logic                scan_active_reg;
    logic [AW-1:0]       scan_age_reg;
    logic [DATA_W-1:0]   acc_min_reg, acc_max_reg;
    logic                publish_reg;

    // Age 0 is the slot just behind the write pointer. Ages up to 2^AW-1
    // are folded back into range; out-of-count ages are masked elsewhere.
    function automatic logic [AW-1:0] age_to_phys(input logic [AW-1:0] wp,
                                                  input logic [AW-1:0] age);
        int p;
        p = int'(wp) + DEPTH - 1 - int'(age);
        if (p < 0)
            p = p + DEPTH;
        else if (p >= DEPTH)
            p = p - DEPTH;
        return AW'(p);
    endfunction

    // ---------------- stability FSM ----------------
    logic              sample_ok;
    logic [DATA_W:0]   diff;
    logic              in_tol;
    logic [RW-1:0]     run_inc;

    assign sample_ok = sample_valid && (sample != '0);
    // Difference taken one bit wider so it never wraps.
    assign diff      = ({1'b0, sample} >= {1'b0, cand_reg}) ?
                       ({1'b0, sample} - {1'b0, cand_reg}) :
                       ({1'b0, cand_reg} - {1'b0, sample});
    assign in_tol    = (diff <= TOL_EXT);
    assign run_inc   = run_reg + RW'(1);

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        run_next   = run_reg;
        commit     = 1'b0;
        if (sample_ok) begin
            case (state_reg)
                IDLE: begin
                    cand_next  = sample;
                    run_next   = RW'(1);
                    state_next = TRACK;
                end
                TRACK: begin
                    if (in_tol) begin
                        run_next = run_inc;
                        if (run_inc == RW'(STABLE_CNT)) begin
                            commit     = 1'b1;
                            state_next = LOCKED;
                        end
                    end else begin
                        cand_next = sample;
                        run_next  = RW'(1);
                    end
                end
                LOCKED: begin
                    if (!in_tol) begin
                        cand_next  = sample;
                        run_next   = RW'(1);
                        state_next = TRACK;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            run_reg   <= '0;
`ifdef HIST_CLEAR_EN
        end else if (clear) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            run_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            run_reg   <= run_next;
        end
    end

    // ---------------- buffer, read ports, browse ----------------
    logic [AW-1:0] rd_phys, browse_phys;
    logic          rd_hit, browse_hit;

    assign rd_phys     = age_to_phys(wr_ptr_reg, rd_age);
    assign browse_phys = age_to_phys(wr_ptr_reg, browse_idx);
    assign rd_hit      = (CW'(rd_age) < count);
    assign browse_hit  = (CW'(browse_idx) < count);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
            wr_ptr_reg  <= '0;
            count       <= '0;
            browse_idx  <= '0;
            save_pulse  <= 1'b0;
            rd_data     <= '0;
            browse_data <= '0;
        end else begin
            // Read ports run every cycle, whatever else happens.
            rd_data     <= rd_hit ? mem_reg[rd_phys] : '0;
            browse_data <= browse_hit ? mem_reg[browse_phys] : '0;
            save_pulse  <= 1'b0;
`ifdef HIST_CLEAR_EN
            if (clear) begin
                wr_ptr_reg <= '0;
                count      <= '0;
                browse_idx <= '0;
            end else
`endif
            if (commit) begin
                mem_reg[wr_ptr_reg] <= cand_reg;
                wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
                if (count != CW'(DEPTH))
                    count <= count + CW'(1);
                save_pulse <= 1'b1;
                browse_idx <= '0;   // a commit overrides a coincident step
            end else if (browse_step) begin
                if (count == '0 || CW'(browse_idx) == count - CW'(1))
                    browse_idx <= '0;
                else
                    browse_idx <= browse_idx + AW'(1);
            end
        end
    end

    // ---------------- min/max scan ----------------
    // One age per cycle from 0 to count-1 into accumulators, then one more
    // cycle to publish. Published values hold until a scan completes.
    logic [DATA_W-1:0] scan_word;
    logic              scan_last;

    assign scan_word = mem_reg[age_to_phys(wr_ptr_reg, scan_age_reg)];
    assign scan_last = (CW'(scan_age_reg) == count - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_active_reg <= 1'b0;
            scan_age_reg    <= '0;
            acc_min_reg     <= '0;
            acc_max_reg     <= '0;
            publish_reg     <= 1'b0;
            min_val         <= '0;
            max_val         <= '0;
            stats_valid     <= 1'b1;
`ifdef HIST_CLEAR_EN
        end else if (clear) begin
            scan_active_reg <= 1'b0;
            scan_age_reg    <= '0;
            publish_reg     <= 1'b0;
            min_val         <= '0;
            max_val         <= '0;
            stats_valid     <= 1'b1;
`endif
        end else if (commit) begin
            // Restart from scratch; any scan in flight is dropped.
            scan_active_reg <= 1'b1;
            scan_age_reg    <= '0;
            publish_reg     <= 1'b0;
            stats_valid     <= 1'b0;
        end else begin
            publish_reg <= 1'b0;
            if (scan_active_reg) begin
                if (scan_age_reg == '0) begin
                    acc_min_reg <= scan_word;
                    acc_max_reg <= scan_word;
                end else begin
                    if (scan_word < acc_min_reg)
                        acc_min_reg <= scan_word;
                    if (scan_word > acc_max_reg)
                        acc_max_reg <= scan_word;
                end
                scan_age_reg <= scan_age_reg + AW'(1);
                if (scan_last) begin
                    scan_active_reg <= 1'b0;
                    publish_reg     <= 1'b1;
                end
            end
            if (publish_reg) begin
                min_val     <= acc_min_reg;
                max_val     <= acc_max_reg;
                stats_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reading_history_buf.sv
// Testbench for reading_history_buf. A reference model (history kept as a
// queue, newest first) predicts every registered output for each clock
// edge; the driver pushes that prediction and a monitor pops and compares
// it on the following falling edge.
module tb_reading_history_buf;
    localparam int DATA_W     = 8;
    localparam int DEPTH      = 10;
    localparam int STABLE_CNT = 4;
    localparam int TOL        = 1;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              browse_step = 1'b0;
    logic [AW-1:0]     rd_age = '0;
    logic [DATA_W-1:0] rd_data, browse_data, min_val, max_val;
    logic [AW-1:0]     browse_idx;
    logic [CW-1:0]     count;
    logic              save_pulse, stats_valid;
`ifdef HIST_CLEAR_EN
    logic              clear = 1'b0;
`endif

    reading_history_buf #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .STABLE_CNT(STABLE_CNT), .TOL(TOL)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef HIST_CLEAR_EN
        .clear(clear),
`endif
        .sample_valid(sample_valid), .sample(sample), .browse_step(browse_step),
        .rd_age(rd_age), .rd_data(rd_data), .browse_idx(browse_idx),
        .browse_data(browse_data), .count(count), .save_pulse(save_pulse),
        .min_val(min_val), .max_val(max_val), .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd_data; int browse_idx; int browse_data; int count;
        int save_pulse; int stats_valid; int min_val; int max_val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   commits_seen = 0;

    // ---------------- reference model ----------------
    int hist[$];          // committed values, hist[0] = newest
    bit m_have;           // a candidate exists (not idle)
    bit m_locked;         // current episode already committed
    int m_cand, m_run, m_bidx;
    int m_sv, m_min, m_max, m_remain, m_pmin, m_pmax;

    function automatic int look(input int age);
        return (age < hist.size()) ? hist[age] : 0;
    endfunction

    task automatic model_clear_all();
        hist.delete();
        m_have = 0; m_locked = 0; m_cand = 0; m_run = 0; m_bidx = 0;
        m_sv = 1; m_min = 0; m_max = 0; m_remain = 0;
    endtask

    task automatic model_edge(input bit r, input bit clr, input bit sv, input int s,
                              input bit bs, input int age, output exp_t e);
        bit commit;
        int n_pre;
        int d;
        commit = 0;
        e.rd_data     = look(age);
        e.browse_data = look(m_bidx);
        e.save_pulse  = 0;
        if (r) begin
            model_clear_all();
            e.rd_data = 0;
            e.browse_data = 0;
        end else if (clr) begin
            model_clear_all();
        end else begin
            if (sv && s != 0) begin
                d = (s > m_cand) ? s - m_cand : m_cand - s;
                if (!m_have) begin
                    m_have = 1; m_cand = s; m_run = 1;
                end else if (d > TOL) begin
                    m_cand = s; m_run = 1; m_locked = 0;
                end else if (!m_locked) begin
                    m_run++;
                    if (m_run == STABLE_CNT) begin
                        commit = 1; m_locked = 1;
                    end
                end
            end
            n_pre = hist.size();
            if (commit)
                m_bidx = 0;
            else if (bs)
                m_bidx = (n_pre == 0) ? 0 : (m_bidx + 1) % n_pre;
            if (commit) begin
                hist.push_front(m_cand);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                m_pmin = hist[0]; m_pmax = hist[0];
                foreach (hist[i]) begin
                    if (hist[i] < m_pmin) m_pmin = hist[i];
                    if (hist[i] > m_pmax) m_pmax = hist[i];
                end
                m_sv = 0;
                m_remain = hist.size() + 1;
            end else if (m_remain > 0) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_sv = 1; m_min = m_pmin; m_max = m_pmax;
                end
            end
            e.save_pulse = commit;
        end
        e.browse_idx  = m_bidx;
        e.count       = hist.size();
        e.stats_valid = m_sv;
        e.min_val     = m_min;
        e.max_val     = m_max;
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit r, input bit clr, input bit sv, input int s, input bit bs);
        exp_t e;
        int   age;
        age = int'($urandom_range(0, 15));
        rst = r; sample_valid = sv; sample = DATA_W'(s);
        browse_step = bs; rd_age = AW'(age);
`ifdef HIST_CLEAR_EN
        clear = clr;
`endif
        model_edge(r, clr, sv, s, bs, age, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic smp(input int v);
        cyc(0, 0, 1, v, ($urandom_range(0, 3) == 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic rep(input int v, input int n);
        for (int i = 0; i < n; i++) smp(v);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data",     32'(rd_data),     e.rd_data);
                chk("browse_idx",  32'(browse_idx),  e.browse_idx);
                chk("browse_data", 32'(browse_data), e.browse_data);
                chk("count",       32'(count),       e.count);
                chk("save_pulse",  32'(save_pulse),  e.save_pulse);
                chk("stats_valid", 32'(stats_valid), e.stats_valid);
                chk("min_val",     32'(min_val),     e.min_val);
                chk("max_val",     32'(max_val),     e.max_val);
                if (e.save_pulse != 0) begin
                    commits_seen++;
                    $display("commit %0d: count=%0d expected_count=%0d", commits_seen, count, e.count);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, s, v;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // single stable episode, then a repeat that must not commit again
        smp(40); smp(40); smp(41); smp(40);
        idle(2);
        smp(40); smp(40);
        // zeros ignored while locked, then a second episode
        smp(0); smp(0); smp(40); smp(40);
        rep(60, 4);
        idle(5);

        // fill beyond DEPTH with values 1..12
        cyc(1, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            smp(50);
            rep(k, 4);
        end
        idle(13);

        // browse wrap with count = 3, then commit coinciding with a step
        cyc(1, 0, 0, 0, 0);
        rep(10, 4); rep(20, 4); rep(30, 4);
        idle(2);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1);
        smp(70); smp(70); smp(70);
        cyc(0, 0, 1, 70, 1);
        idle(2);

        // commit in the middle of a scan, then reset with run = 3
        rep(90, 4);
        idle(2);
        rep(5, 4);
        idle(8);
        smp(120); smp(120); smp(120);
        cyc(1, 0, 0, 0, 0);
        idle(3);

`ifdef HIST_CLEAR_EN
        for (int k = 0; k < 5; k++) begin
            smp(200);
            rep(10 + k * 10, 4);
        end
        idle(8);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0, 0);
        rep(33, 3);
        cyc(0, 1, 1, 33, 0);
        idle(3);
`endif

        // randomized phase
        base = 100;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) base = int'($urandom_range(5, 250));
            v = int'($urandom_range(0, 4)) - 2;
            s = base + v;
            if ($urandom_range(0, 19) == 0) s = 0;
            if ($urandom_range(0, 499) == 0)
                cyc(1, 0, 0, 0, 0);
`ifdef HIST_CLEAR_EN
            else if ($urandom_range(0, 199) == 0)
                cyc(0, 1, ($urandom_range(0, 1) == 1), s, 0);
`endif
            else
                cyc(0, 0, ($urandom_range(0, 3) != 0), s, ($urandom_range(0, 5) == 0));
        end

        idle(2);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
